// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM-download sequencer: FSM states, region index, error bit positions.
package rom_dl_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    typedef logic [1:0] region_t;

    localparam int ERR_SIZE = 0;
    localparam int ERR_SUM  = 1;

    function automatic logic [3:0] region_onehot(input region_t region);
        region_onehot = 4'b0001 << region;
    endfunction

endpackage

// File: rtl/rom_dl_region_dec.sv
// Combinational decode of an ioctl byte address into a one-hot ROM region,
// the region-relative address and an in-range flag.
module rom_dl_region_dec
    import rom_dl_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int unsigned R1_BASE    = 32'h6000,
    parameter int unsigned R2_BASE    = 32'h8000,
    parameter int unsigned R3_BASE    = 32'hA000,
    parameter int unsigned TOTAL_SIZE = 32'hA060
) (
    input  logic [24:0]       addr,
    output logic [3:0]        region_we,
    output logic [ADDR_W-1:0] rel_addr,
    output logic              in_range
);

    logic [31:0] addr_ext;
    logic [31:0] base;
    logic [31:0] diff;
    region_t     region;

    always_comb begin
        addr_ext = {7'd0, addr};
        region   = 2'd0;
        base     = 32'd0;
        if (addr_ext < R1_BASE) begin
            region = 2'd0;
            base   = 32'd0;
        end else if (addr_ext < R2_BASE) begin
            region = 2'd1;
            base   = R1_BASE;
        end else if (addr_ext < R3_BASE) begin
            region = 2'd2;
            base   = R2_BASE;
        end else begin
            region = 2'd3;
            base   = R3_BASE;
        end
        diff      = addr_ext - base;
        rel_addr  = diff[ADDR_W-1:0];
        in_range  = addr_ext < TOTAL_SIZE;
        region_we = region_onehot(region);
    end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Routes the HPS ROM-download stream into four ROM regions and owns the game-core reset.
// Optional feature: define ROM_DL_CHECKSUM_EN to validate an 8-bit additive checksum.
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int unsigned R1_BASE     = 32'h6000,
    parameter int unsigned R2_BASE     = 32'h8000,
    parameter int unsigned R3_BASE     = 32'hA000,
    parameter int unsigned TOTAL_SIZE  = 32'hA060,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter logic [7:0]  EXP_SUM     = 8'h00
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              rst_req,
    output logic [3:0]        rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              core_reset,
    output logic              dl_done,
    output logic [1:0]        dl_error,
    output logic [ADDR_W:0]   dl_count
);

    localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]  COUNT_MAX = '1;
    localparam logic [ADDR_W:0]  COUNT_EXP = (ADDR_W + 1)'(TOTAL_SIZE);

    state_t            state;
    logic              dl_q;
    logic [CNT_W-1:0]  hold_cnt;
    logic              dl_rise;
    logic              dl_fall;
    logic              wr_ok;
    logic              sum_ok;
    logic [3:0]        region_we;
    logic [ADDR_W-1:0] rel_addr;
    logic              in_range;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    // dl_q high excludes the rise cycle, so a write coincident with the rise is dropped
    assign wr_ok   = (state == LOAD) && dl_q && ioctl_download && ioctl_wr;

    rom_dl_region_dec #(
        .ADDR_W    (ADDR_W),
        .R1_BASE   (R1_BASE),
        .R2_BASE   (R2_BASE),
        .R3_BASE   (R3_BASE),
        .TOTAL_SIZE(TOTAL_SIZE)
    ) u_dec (
        .addr     (ioctl_addr),
        .region_we(region_we),
        .rel_addr (rel_addr),
        .in_range (in_range)
    );

`ifdef ROM_DL_CHECKSUM_EN
    logic [7:0] sum;

    assign sum_ok = (sum == EXP_SUM);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum <= 8'd0;
        end else if (dl_rise) begin
            sum <= 8'd0;
        end else if (wr_ok && in_range) begin
            sum <= sum + ioctl_dout;
        end
    end
`else
    assign sum_ok = 1'b1;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            dl_done    <= 1'b0;
            dl_error   <= 2'b00;
            dl_count   <= '0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_rise) begin
                state      <= LOAD;
                core_reset <= 1'b1;
                dl_done    <= 1'b0;
                dl_error   <= 2'b00;
                dl_count   <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (wr_ok) begin
                            if (in_range) begin
                                if (dl_count != COUNT_MAX)
                                    dl_count <= dl_count + 1'b1;
                            end else begin
                                dl_error[ERR_SIZE] <= 1'b1;
                            end
                        end
                        if (dl_fall) begin
                            if ((dl_count == COUNT_EXP) && sum_ok) begin
                                state    <= HOLD;
                                hold_cnt <= HOLD_LOAD;
                                dl_done  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                if (dl_count != COUNT_EXP)
                                    dl_error[ERR_SIZE] <= 1'b1;
                                dl_error[ERR_SUM] <= ~sum_ok;
                            end
                        end
                    end
                    HOLD, RUN: begin
                        if (rst_req) begin
                            state      <= HOLD;
                            hold_cnt   <= HOLD_LOAD;
                            core_reset <= 1'b1;
                        end else if (state == HOLD) begin
                            if (hold_cnt == '0) begin
                                state      <= RUN;
                                core_reset <= 1'b0;
                            end else begin
                                hold_cnt <= hold_cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Write path: one registered cycle between ioctl_wr and the region strobe
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_we   <= 4'b0000;
            rom_addr <= '0;
            rom_data <= 8'd0;
        end else begin
            rom_we <= (wr_ok && in_range) ? region_we : 4'b0000;
            if (wr_ok && in_range) begin
                rom_addr <= rel_addr;
                rom_data <= ioctl_dout;
            end
        end
    end

endmodule
